grid_frame_compositor: RTL

Parametrised successor to the single-snake/single-coin screen logic. It owns an H×V tile memory and a colour palette. On each `frame_start` it runs a frame-build sequence: clear the grid, draw a streamed list of body segments, then draw N independently enabled items. It continuously maps VGA pixel coordinates to a palette colour for the display mux. Game logic (movement, collision, scoring) stays upstream; this block only composes and scans out the grid.

---
 rtl/grid_frame_compositor.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/grid_frame_compositor.sv
// Tile-grid frame compositor: clears an HxV index grid, draws streamed segments and items, scans out palette colours.
// Optional feature: define GRID_PALETTE_EN for a writable palette register file (otherwise fixed BG/FG colours).
module grid_frame_compositor #(
  parameter int H          = 32,
  parameter int V          = 32,
  // Overridable so coordinate ports can carry values beyond the grid when H/V are powers of two.
  parameter int XB         = $clog2(H),
  parameter int YB         = $clog2(V),
  parameter int POS_X      = 10,
  parameter int POS_Y      = 10,
  parameter int SCALE_X    = 2,
  parameter int SCALE_Y    = 2,
  parameter int N_ITEMS    = 4,
  parameter int IDX_BITS   = 2,
  parameter int COLOR_BITS = 8,
  parameter logic [COLOR_BITS-1:0] BG_COLOR = 'h00,
  parameter logic [COLOR_BITS-1:0] FG_COLOR = 'hFF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         frame_start,
  input  logic                         seg_valid,
  output logic                         seg_ready,
  input  logic [XB-1:0]                seg_x,
  input  logic [YB-1:0]                seg_y,
  input  logic [IDX_BITS-1:0]          seg_idx,
  input  logic                         seg_last,
  input  logic [N_ITEMS*XB-1:0]        item_x,
  input  logic [N_ITEMS*YB-1:0]        item_y,
  input  logic [N_ITEMS*IDX_BITS-1:0]  item_idx,
  input  logic [N_ITEMS-1:0]           item_en,
  input  logic                         pal_we,
  input  logic [IDX_BITS-1:0]          pal_addr,
  input  logic [COLOR_BITS-1:0]        pal_data,
  input  logic [9:0]                   eval_x,
  input  logic [9:0]                   eval_y,
  output logic [COLOR_BITS-1:0]        out_color,
  output logic                         color_valid,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         overrun,
  output logic                         clipped
);

  localparam int CELLS = H * V;
  localparam int AW    = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int IW    = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;
  localparam int SX_SH = $clog2(SCALE_X);
  localparam int SY_SH = $clog2(SCALE_Y);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_SEGS  = 3'd2;
  localparam logic [2:0] S_ITEMS = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]                  state;
  logic [AW-1:0]               clr_cnt;
  logic [IW-1:0]               item_cnt;
  logic [N_ITEMS*XB-1:0]       snap_x;
  logic [N_ITEMS*YB-1:0]       snap_y;
  logic [N_ITEMS*IDX_BITS-1:0] snap_idx;
  logic [N_ITEMS-1:0]          snap_en;
  logic                        overrun_q;
  logic                        clipped_q;

  logic                        wr_en;
  logic [AW-1:0]               wr_addr;
  logic [IDX_BITS-1:0]         wr_data;
  logic                        drop;
  logic [AW-1:0]               rd_addr;
  logic [IDX_BITS-1:0]         rd_data;
  logic [COLOR_BITS-1:0]       idx_color;
  logic                        in_win;
  logic [9:0]                  dx;
  logic [9:0]                  dy;

  logic [XB-1:0]               it_x;
  logic [YB-1:0]               it_y;
  logic [IDX_BITS-1:0]         it_idx;
  logic                        it_en;

  function automatic logic [AW-1:0] cell_addr(input int unsigned x, input int unsigned y);
    int unsigned a;
    a = y * H + x;
    return a[AW-1:0];
  endfunction

  assign busy       = (state == S_CLEAR) || (state == S_SEGS) || (state == S_ITEMS);
  assign frame_done = (state == S_DONE);
  assign seg_ready  = (state == S_SEGS);
  assign overrun    = overrun_q;
  assign clipped    = clipped_q;

  assign it_x   = snap_x[32'(item_cnt)*XB +: XB];
  assign it_y   = snap_y[32'(item_cnt)*YB +: YB];
  assign it_idx = snap_idx[32'(item_cnt)*IDX_BITS +: IDX_BITS];
  assign it_en  = snap_en[item_cnt];

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    drop    = 1'b0;
    case (state)
      S_CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = clr_cnt;
      end
      S_SEGS: begin
        if (seg_valid) begin
          if ((32'(seg_x) < H) && (32'(seg_y) < V)) begin
            wr_en   = 1'b1;
            wr_addr = cell_addr(32'(seg_x), 32'(seg_y));
            wr_data = seg_idx;
          end else begin
            drop = 1'b1;
          end
        end
      end
      S_ITEMS: begin
        if (it_en) begin
          if ((32'(it_x) < H) && (32'(it_y) < V)) begin
            wr_en   = 1'b1;
            wr_addr = cell_addr(32'(it_x), 32'(it_y));
            wr_data = it_idx;
          end else begin
            drop = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Build sequencer; a frame_start arriving mid-build is only recorded as an overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      clr_cnt   <= '0;
      item_cnt  <= '0;
      overrun_q <= 1'b0;
      clipped_q <= 1'b0;
    end else begin
      if (drop) clipped_q <= 1'b1;
      if (frame_start && busy) overrun_q <= 1'b1;
      case (state)
        S_IDLE, S_DONE: begin
          clr_cnt <= '0;
          state   <= frame_start ? S_CLEAR : S_IDLE;
        end
        S_CLEAR: begin
          if (clr_cnt == AW'(CELLS - 1)) state <= S_SEGS;
          else clr_cnt <= clr_cnt + 1'b1;
        end
        S_SEGS: begin
          if (seg_valid && seg_last) begin
            state    <= S_ITEMS;
            item_cnt <= '0;
          end
        end
        S_ITEMS: begin
          if (item_cnt == IW'(N_ITEMS - 1)) state <= S_DONE;
          else item_cnt <= item_cnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (((state == S_IDLE) || (state == S_DONE)) && frame_start) begin
      snap_x   <= item_x;
      snap_y   <= item_y;
      snap_idx <= item_idx;
      snap_en  <= item_en;
    end
  end

  assign dx     = eval_x - 10'(POS_X);
  assign dy     = eval_y - 10'(POS_Y);
  assign in_win = (32'(eval_x) >= POS_X) && (32'(eval_x) < POS_X + SCALE_X * H) &&
                  (32'(eval_y) >= POS_Y) && (32'(eval_y) < POS_Y + SCALE_Y * V);
  assign rd_addr = in_win ? cell_addr(32'(dx >> SX_SH), 32'(dy >> SY_SH)) : '0;

  // Tile RAM: one write port for the builder, one registered read port for scan-out (read-old on collision).
  logic [IDX_BITS-1:0] tile_mem [CELLS];

  always_ff @(posedge clk) begin
    if (wr_en) tile_mem[wr_addr] <= wr_data;
    rd_data <= tile_mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) color_valid <= 1'b0;
    else color_valid <= in_win;
  end

`ifdef GRID_PALETTE_EN
  logic [COLOR_BITS-1:0] palette [2**IDX_BITS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2**IDX_BITS; i++) palette[i] <= (i == 0) ? BG_COLOR : FG_COLOR;
    end else if (pal_we) begin
      palette[pal_addr] <= pal_data;
    end
  end

  assign idx_color = palette[rd_data];
`else
  logic unused_pal;
  assign unused_pal = ^{pal_we, pal_addr, pal_data};
  assign idx_color  = (rd_data == '0) ? BG_COLOR : FG_COLOR;
`endif

  assign out_color = color_valid ? idx_color : '0;

endmodule
